puf_eval_ctrl: RTL

//  - Sequencer in front of the PUF array. Accepts a read request for one PUF word address and runs NUM_EVALS reset/start/sample evaluations.
//  - Majority-votes each bit across the evaluations and returns the voted word on a valid/ready response channel.
//  - Owns the array's reset, START and addr inputs; reads the array's registered word output.

---
 rtl/puf_ctrl_pkg.sv | 23 ++
 rtl/puf_vote_acc.sv | 56 +++++
 rtl/puf_eval_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared state encoding, counter widths and helpers for the PUF
// evaluation controller (puf_eval_ctrl and puf_vote_acc).
package puf_ctrl_pkg;

  // Width of the per-request evaluation counter.
  localparam int unsigned EVAL_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    ARM,
    WAIT,
    SAMP,
    VOTE,
    RESP
  } state_t;

  // Per-bit vote counter width: must hold 0..num_evals.
  function automatic int unsigned vote_cnt_w(input int unsigned num_evals);
    return $clog2(num_evals + 1);
  endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// puf_vote_acc: per-bit vote counters for the PUF evaluation controller.
//   clk, reset_n  : clock, async active-low reset
//   clr           : zero all counters (start of a request)
//   acc           : add word[i] into counter i
//   word          : sampled PUF word
//   majority_c    : combinational majority (2*cnt > NUM_EVALS, ties -> 0)
//   unstable_c    : combinational flip flag (cnt neither 0 nor NUM_EVALS),
//                   present only when PUF_STABILITY_MASK_EN is defined
module puf_vote_acc
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned OUT_BITS  = 8,
  parameter int unsigned NUM_EVALS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                acc,
  input  logic [OUT_BITS-1:0] word,
`ifdef PUF_STABILITY_MASK_EN
  output logic [OUT_BITS-1:0] unstable_c,
`endif
  output logic [OUT_BITS-1:0] majority_c
);

  localparam int unsigned VW = vote_cnt_w(NUM_EVALS);

  logic [VW-1:0] vote_cnt [OUT_BITS];

  // Counters saturate naturally: at most NUM_EVALS accumulates per request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < OUT_BITS; i++) vote_cnt[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < OUT_BITS; i++) vote_cnt[i] <= '0;
    end else if (acc) begin
      for (int unsigned i = 0; i < OUT_BITS; i++) vote_cnt[i] <= vote_cnt[i] + VW'(word[i]);
    end
  end

  // Doubling the count avoids a divide and makes even-count ties resolve to 0.
  always_comb begin
    majority_c = '0;
    for (int unsigned i = 0; i < OUT_BITS; i++)
      majority_c[i] = {vote_cnt[i], 1'b0} > (VW+1)'(NUM_EVALS);
  end

`ifdef PUF_STABILITY_MASK_EN
  always_comb begin
    unstable_c = '0;
    for (int unsigned i = 0; i < OUT_BITS; i++)
      unstable_c[i] = (vote_cnt[i] != '0) && (vote_cnt[i] != VW'(NUM_EVALS));
  end
`endif

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences NUM_EVALS reset/start/sample evaluations of one PUF
// word and returns the bitwise majority on a valid/ready response channel.
// Optional feature macro: PUF_STABILITY_MASK_EN adds resp_unstable.
//   clk, reset_n          : clock, async active-low reset
//   req_valid/ready/addr  : request channel (one request in flight)
//   resp_valid/ready/data : response channel, data = voted word
//   resp_unstable         : per-bit flip flags (PUF_STABILITY_MASK_EN only)
//   busy                  : high outside IDLE
//   puf_reset/start/addr  : drive the PUF array
//   puf_word              : registered word from the array
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 4,
  parameter int unsigned OUT_BITS      = 8,
  parameter int unsigned NUM_EVALS     = 5,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [OUT_BITS-1:0]  resp_data,
`ifdef PUF_STABILITY_MASK_EN
  output logic [OUT_BITS-1:0]  resp_unstable,
`endif
  output logic                 busy,
  output logic                 puf_reset,
  output logic                 puf_start,
  output logic [ADDR_BITS-1:0] puf_addr,
  input  logic [OUT_BITS-1:0]  puf_word
);

  localparam int unsigned PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [EVAL_CNT_W:0] NUM_EVALS_X = (EVAL_CNT_W+1)'(NUM_EVALS);

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [EVAL_CNT_W-1:0] eval_q, eval_d;
  logic                  req_ready_d, resp_valid_d, busy_d, puf_reset_d, puf_start_d;
  logic [OUT_BITS-1:0]   resp_data_d;
  logic [ADDR_BITS-1:0]  puf_addr_d;
  logic                  vote_clr, vote_acc;
  logic [OUT_BITS-1:0]   majority_c;
`ifdef PUF_STABILITY_MASK_EN
  logic [OUT_BITS-1:0]   unstable_c;
  logic [OUT_BITS-1:0]   resp_unstable_d;
`endif

  puf_vote_acc #(
    .OUT_BITS  (OUT_BITS),
    .NUM_EVALS (NUM_EVALS)
  ) u_vote (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (vote_clr),
    .acc        (vote_acc),
    .word       (puf_word),
`ifdef PUF_STABILITY_MASK_EN
    .unstable_c (unstable_c),
`endif
    .majority_c (majority_c)
  );

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      eval_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      puf_reset  <= 1'b1;
      puf_start  <= 1'b0;
      puf_addr   <= '0;
`ifdef PUF_STABILITY_MASK_EN
      resp_unstable <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      eval_q     <= eval_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      busy       <= busy_d;
      puf_reset  <= puf_reset_d;
      puf_start  <= puf_start_d;
      puf_addr   <= puf_addr_d;
`ifdef PUF_STABILITY_MASK_EN
      resp_unstable <= resp_unstable_d;
`endif
    end
  end

  // Next state and next output values; outputs change together with the state.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    eval_d       = eval_q;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    busy_d       = busy;
    puf_reset_d  = puf_reset;
    puf_start_d  = puf_start;
    puf_addr_d   = puf_addr;
    vote_clr     = 1'b0;
    vote_acc     = 1'b0;
`ifdef PUF_STABILITY_MASK_EN
    resp_unstable_d = resp_unstable;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = RST;
          phase_d     = '0;
          eval_d      = '0;
          vote_clr    = 1'b1;
          puf_addr_d  = req_addr;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          puf_reset_d = 1'b1;
          puf_start_d = 1'b0;
        end
      end
      RST: begin
        if (phase_q == PH_W'(RST_CYCLES - 1)) begin
          state_d     = ARM;
          phase_d     = '0;
          puf_reset_d = 1'b0;
          puf_start_d = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ARM: begin
        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = WAIT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      // One extra cycle so puf_word reflects the settled array output.
      WAIT: state_d = SAMP;
      SAMP: begin
        vote_acc    = 1'b1;
        puf_start_d = 1'b0;
        puf_reset_d = 1'b1;
        if ({1'b0, eval_q} + (EVAL_CNT_W+1)'(1) < NUM_EVALS_X) begin
          state_d = RST;
          eval_d  = eval_q + EVAL_CNT_W'(1);
        end else begin
          state_d = VOTE;
        end
      end
      VOTE: begin
        state_d      = RESP;
        resp_data_d  = majority_c;
        resp_valid_d = 1'b1;
        puf_reset_d  = 1'b1;
`ifdef PUF_STABILITY_MASK_EN
        resp_unstable_d = unstable_c;
`endif
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
